// File: rtl/click_pulse_gen.sv
// click_pulse_gen: independent gap/click trains, one per channel, for LED/piezo/speaker drivers.
// Define JITTER_EN to stretch every gap by a pseudo-random amount from a shared 16-bit LFSR.
module click_pulse_gen #(
    parameter int N_CH       = 4,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 32,
    parameter int GAP_CYCLES = 30000,
    parameter int ON_UNIT    = 1 << 20,
    parameter int JIT_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic [N_CH*SEL_W-1:0]   i_sel,
    output logic [N_CH-1:0]         o_click,
    output logic [N_CH-1:0]         o_click_stb,
    output logic                    o_any
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        CLICK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNIT     = CNT_W'(ON_UNIT);
    localparam logic [CNT_W-1:0] SEL_SPAN = CNT_W'(2 ** SEL_W);

    logic [N_CH-1:0] click_d;
    logic [N_CH-1:0] stb_d;

`ifdef JITTER_EN
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    logic [15:0] lfsr_q;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [SEL_W-1:0] sel_q, sel_d;
        logic [SEL_W-1:0] sel_in;
        logic [CNT_W-1:0] gap_last;
        logic [CNT_W-1:0] entry_last;
        logic [CNT_W-1:0] on_last;
        logic             run;
        logic             click_n;
        logic             stb_n;

        assign sel_in  = i_sel[c*SEL_W +: SEL_W];
        assign run     = i_en && (sel_in != '0);
        assign on_last = UNIT * (SEL_SPAN - CNT_W'(sel_q)) - CNT_W'(1);

`ifdef JITTER_EN
        logic [JIT_W-1:0] jit_q, jit_d, jit_new;

        assign jit_new    = lfsr_q[JIT_W-1:0] ^ JIT_W'(c);
        assign entry_last = GAP_LAST + CNT_W'(jit_new);
        // In the first gap cycle the jitter is being latched, so use the fresh value.
        assign gap_last   = (cnt_q == '0) ? entry_last : GAP_LAST + CNT_W'(jit_q);
`else
        assign entry_last = GAP_LAST;
        assign gap_last   = GAP_LAST;
`endif

        always_comb begin
            // NOTE: every signal written here gets a default first, so no path infers a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            sel_d   = sel_q;
            click_n = 1'b0;
            stb_n   = 1'b0;
`ifdef JITTER_EN
            jit_d   = jit_q;
`endif
            if (!run) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // The enabling cycle already counts as gap cycle 0.
                        sel_d = sel_in;
`ifdef JITTER_EN
                        jit_d = jit_new;
`endif
                        if (entry_last == '0) begin
                            state_d = CLICK;
                            cnt_d   = '0;
                            click_n = 1'b1;
                            stb_n   = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_q == '0) begin
                            sel_d = sel_in;
`ifdef JITTER_EN
                            jit_d = jit_new;
`endif
                        end
                        if (cnt_q >= gap_last) begin
                            state_d = CLICK;
                            cnt_d   = '0;
                            click_n = 1'b1;
                            stb_n   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    CLICK: begin
                        if (cnt_q >= on_last) begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            click_n = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge i_clk) begin
            if (reset) begin
                state_q <= GAP;
                cnt_q   <= '0;
                sel_q   <= '0;
`ifdef JITTER_EN
                jit_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sel_q   <= sel_d;
`ifdef JITTER_EN
                jit_q   <= jit_d;
`endif
            end
        end

        assign click_d[c] = click_n;
        assign stb_d[c]   = stb_n;
    end

    // All three outputs come from the same next-state terms, keeping them cycle-aligned.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            o_click     <= '0;
            o_click_stb <= '0;
            o_any       <= 1'b0;
        end else begin
            o_click     <= click_d;
            o_click_stb <= stb_d;
            o_any       <= |click_d;
        end
    end

endmodule
